// File: rtl/cpu_pkg.sv
// Shared definitions for the A/B accumulator CPU sequencer.
//   state_t     : sequencer states
//   CLS_*       : instruction class codes (opCode[15:12])
//   WB_*        : writeback mux selects
//   ZNC_*       : bit positions inside the flag register
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, WB, RETIRE, HALT
  } state_t;

  localparam logic [3:0] CLS_NOP    = 4'h0;
  localparam logic [3:0] CLS_ALU_LO = 4'h1;
  localparam logic [3:0] CLS_ALU_HI = 4'h7;
  localparam logic [3:0] CLS_LOAD   = 4'h8;
  localparam logic [3:0] CLS_STORE  = 4'h9;
  localparam logic [3:0] CLS_BR     = 4'hA;
  localparam logic [3:0] CLS_BRZ    = 4'hB;
  localparam logic [3:0] CLS_BRN    = 4'hC;
  localparam logic [3:0] CLS_BRC    = 4'hD;
  localparam logic [3:0] CLS_CMP    = 4'hE;
  localparam logic [3:0] CLS_HALT   = 4'hF;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_HOLD = 2'd2;

  localparam int ZNC_Z = 2;
  localparam int ZNC_N = 1;
  localparam int ZNC_C = 0;

endpackage

// File: rtl/cpu_seq_ctrl_op_decode.sv
// op_decode: combinational instruction classifier.
//   op_code  in  OPW  instruction word (class in [15:12], dst in [11])
//   znc      in  3    flag register, used only for the branch decision
//   is_*     out 1    one-hot-ish class flags (all low for NOP)
//   br_taken out 1    branch class and its condition holds
//   dst      out 1    0=A, 1=B
module op_decode
  import cpu_pkg::*;
#(
  parameter int OPW = 16
) (
  input  logic [OPW-1:0] op_code,
  input  logic [2:0]     znc,
  output logic           is_alu,
  output logic           is_cmp,
  output logic           is_load,
  output logic           is_store,
  output logic           is_branch,
  output logic           br_taken,
  output logic           is_halt,
  output logic           dst
);

  logic [3:0] cls;
  logic       unused_low;

  assign cls        = op_code[15:12];
  assign dst        = op_code[11];
  assign unused_low = ^op_code[OPW-6:0];

  assign is_alu    = (cls >= CLS_ALU_LO) && (cls <= CLS_ALU_HI);
  assign is_cmp    = (cls == CLS_CMP);
  assign is_load   = (cls == CLS_LOAD);
  assign is_store  = (cls == CLS_STORE);
  assign is_branch = (cls >= CLS_BR) && (cls <= CLS_BRC);
  assign is_halt   = (cls == CLS_HALT);

  always_comb begin
    br_taken = 1'b0;
    case (cls)
      CLS_BR:  br_taken = 1'b1;
      CLS_BRZ: br_taken = znc[ZNC_Z];
      CLS_BRN: br_taken = znc[ZNC_N];
      CLS_BRC: br_taken = znc[ZNC_C];
      default: br_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: multi-cycle sequencer for the A/B accumulator datapath.
// Steps FETCH -> DECODE -> (EXEC | MEM [-> WB]) -> RETIRE and drives the
// register strobes, PC control and the data-memory handshake.
//   clk, rst_n        clock, synchronous active-low reset
//   run               level; starts from IDLE, HALT exits on its rising edge
//   opCode            instruction word, sampled in DECODE
//   ZNC               flags, sampled live in EXEC for branches
//   mem_ack           one-cycle memory completion, honoured only in MEM
//   pc_en, BR         PC advance / branch load
//   a_we,b_we,znc_we  register load strobes
//   wb_sel            0=ALU, 1=memory, 2=hold
//   mem_req, WE       memory request, store when WE=1
//   halted            in HALT
//   retired           completed-instruction count, wraps
// All outputs are decoded from the registered state (plus ZNC for the branch
// decision) so they are stable across the whole cycle before the ~clk capture.
module cpu_seq_ctrl
  import cpu_pkg::*;
#(
  parameter int OPW  = 16,
  parameter int RETW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic [OPW-1:0]  opCode,
  input  logic [2:0]      ZNC,
  input  logic            mem_ack,
  output logic            pc_en,
  output logic            BR,
  output logic            a_we,
  output logic            b_we,
  output logic            znc_we,
  output logic [1:0]      wb_sel,
  output logic            mem_req,
  output logic            WE,
  output logic            halted,
  output logic [RETW-1:0] retired
);

  state_t          state, nxt;
  logic [3:0]      cls_q;
  logic            dst_q;
  logic            run_q;
  logic [RETW-1:0] ret_cnt;
  logic [OPW-1:0]  dec_op;

  logic is_alu, is_cmp, is_load, is_store, is_branch, br_taken, is_halt, dst;

  // DECODE classifies the live word; afterwards the latched class/dst is
  // re-presented so the fetch unit is free to move on.
  assign dec_op = (state == DECODE) ? opCode : {cls_q, dst_q, {(OPW-5){1'b0}}};

  op_decode #(.OPW(OPW)) u_dec (
    .op_code  (dec_op),
    .znc      (ZNC),
    .is_alu   (is_alu),
    .is_cmp   (is_cmp),
    .is_load  (is_load),
    .is_store (is_store),
    .is_branch(is_branch),
    .br_taken (br_taken),
    .is_halt  (is_halt),
    .dst      (dst)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cls_q   <= CLS_NOP;
      dst_q   <= 1'b0;
      run_q   <= 1'b0;
      ret_cnt <= '0;
    end else begin
      state <= nxt;
      run_q <= run;
      if (state == DECODE) begin
        cls_q <= opCode[15:12];
        dst_q <= opCode[11];
      end
      if (state == RETIRE) ret_cnt <= ret_cnt + RETW'(1);
    end
  end

  assign retired = ret_cnt;

  always_comb begin
    nxt     = state;
    pc_en   = 1'b0;
    BR      = 1'b0;
    a_we    = 1'b0;
    b_we    = 1'b0;
    znc_we  = 1'b0;
    wb_sel  = WB_HOLD;
    mem_req = 1'b0;
    WE      = 1'b0;
    halted  = 1'b0;
    case (state)
      IDLE:   if (run) nxt = FETCH;
      FETCH: begin
        pc_en = 1'b1;
        nxt   = DECODE;
      end
      DECODE: begin
        if (is_halt)                      nxt = HALT;
        else if (is_load || is_store)     nxt = MEM;
        else if (is_alu || is_cmp || is_branch) nxt = EXEC;
        else                              nxt = RETIRE;
      end
      EXEC: begin
        if (is_alu) begin
          a_we   = ~dst;
          b_we   = dst;
          znc_we = 1'b1;
          wb_sel = WB_ALU;
        end
        if (is_cmp) znc_we = 1'b1;
        if (br_taken) begin
          pc_en = 1'b1;
          BR    = 1'b1;
        end
        nxt = RETIRE;
      end
      MEM: begin
        mem_req = 1'b1;
        WE      = is_store;
        if (mem_ack) nxt = is_load ? WB : RETIRE;
      end
      WB: begin
        a_we   = ~dst;
        b_we   = dst;
        wb_sel = WB_MEM;
        nxt    = RETIRE;
      end
      RETIRE: nxt = run ? FETCH : IDLE;
      HALT: begin
        halted = 1'b1;
        // Needs a fresh 0->1 on run, a run held high keeps us parked.
        if (run && !run_q) nxt = FETCH;
      end
      default: nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Self-checking bench for cpu_seq_ctrl: an instruction-level model predicts
// every output each cycle; directed sequences pin literal expectations.
module tb_cpu_seq_ctrl;

  localparam int RW    = 10;  // narrow counter so the wrap is reachable quickly
  localparam int RMASK = (1 << RW) - 1;

  logic          clk = 1'b0;
  logic          rst_n, run, mem_ack;
  logic [15:0]   opCode;
  logic [2:0]    ZNC;
  logic          pc_en, BR, a_we, b_we, znc_we, mem_req, WE, halted;
  logic [1:0]    wb_sel;
  logic [RW-1:0] retired;

  int n_chk = 0;
  int n_fail = 0;

  cpu_seq_ctrl #(.OPW(16), .RETW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opCode(opCode), .ZNC(ZNC),
    .mem_ack(mem_ack), .pc_en(pc_en), .BR(BR), .a_we(a_we), .b_we(b_we),
    .znc_we(znc_we), .wb_sel(wb_sel), .mem_req(mem_req), .WE(WE),
    .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] dut_vec();
    return {pc_en, BR, a_we, b_we, znc_we, wb_sel, mem_req, WE, halted};
  endfunction

  // ---------------- behavioural model ----------------
  typedef enum int {M_IDLE, M_RUN, M_HALT} mmode_t;
  localparam int K_FETCH = 0, K_DEC = 1, K_EXEC = 2, K_MEM = 3, K_WB = 4, K_RET = 5;

  mmode_t     mmode = M_IDLE;
  int         pos = 0;       // cycles since FETCH of the current instruction
  int         ack_pos = -1;  // pos of the accepted ack, -1 before it
  logic [3:0] mcls = 4'h0;
  logic       mdst = 1'b0;
  logic       prev_run = 1'b0;
  int         ret = 0;
  bit         mvalid = 0;

  // What the current cycle is doing, from latency rules per class.
  function automatic int kind();
    if (pos == 0) return K_FETCH;
    if (pos == 1) return K_DEC;
    if (mcls == 4'h0) return K_RET;
    if (mcls == 4'h8 || mcls == 4'h9) begin
      if (ack_pos < 0) return K_MEM;
      if (mcls == 4'h9) return K_RET;
      return (pos == ack_pos + 1) ? K_WB : K_RET;
    end
    return (pos == 2) ? K_EXEC : K_RET;
  endfunction

  function automatic logic [9:0] exp_vec();
    logic pc = 0, br = 0, a = 0, b = 0, z = 0, rq = 0, we = 0, h = 0;
    logic [1:0] ws = 2'd2;
    logic tk;
    if (mmode == M_HALT) h = 1;
    if (mmode == M_RUN) begin
      case (kind())
        K_FETCH: pc = 1;
        K_EXEC: begin
          if (mcls >= 4'h1 && mcls <= 4'h7) begin
            a = !mdst; b = mdst; z = 1; ws = 2'd0;
          end else if (mcls == 4'hE) z = 1;
          else begin
            tk = (mcls == 4'hA) || (mcls == 4'hB && ZNC[2]) ||
                 (mcls == 4'hC && ZNC[1]) || (mcls == 4'hD && ZNC[0]);
            pc = tk; br = tk;
          end
        end
        K_MEM: begin rq = 1; we = (mcls == 4'h9); end
        K_WB:  begin a = !mdst; b = mdst; ws = 2'd1; end
        default: ;
      endcase
    end
    return {pc, br, a, b, z, ws, rq, we, h};
  endfunction

  always @(posedge clk) begin
    int k;
    if (!rst_n) begin
      mmode <= M_IDLE; ret <= 0; prev_run <= 1'b0;
      pos <= 0; ack_pos <= -1; mvalid <= 1;
    end else if (mvalid) begin
      case (mmode)
        M_IDLE: if (run) begin mmode <= M_RUN; pos <= 0; ack_pos <= -1; end
        M_HALT: if (run && !prev_run) begin mmode <= M_RUN; pos <= 0; ack_pos <= -1; end
        default: begin
          k = kind();
          if (k == K_RET) begin
            ret <= (ret + 1) & RMASK;
            if (run) begin pos <= 0; ack_pos <= -1; end
            else mmode <= M_IDLE;
          end else begin
            if (k == K_DEC) begin
              mcls <= opCode[15:12];
              mdst <= opCode[11];
              if (opCode[15:12] == 4'hF) mmode <= M_HALT;
            end
            if (k == K_MEM && mem_ack) ack_pos <= pos;
            pos <= pos + 1;
          end
        end
      endcase
      prev_run <= run;
    end
  end

  // One compare process: every cycle after the first reset edge.
  always @(negedge clk) begin
    #3;
    if (mvalid) begin
      chk("outputs", 32'(dut_vec()), 32'(exp_vec()));
      chk("retired", 32'(retired), 32'(ret));
    end
  end

  // ---------------- directed helpers ----------------
  logic       r_pc[16], r_br[16], r_a[16], r_b[16], r_z[16], r_req[16], r_we[16], r_h[16];
  logic [1:0] r_wb[16];
  int         r_ret[16];

  // Launch one instruction from IDLE, drop run immediately, record ncyc cycles.
  task automatic one_instr(input logic [15:0] op, input logic [2:0] z, input int ack_i, input int ncyc);
    @(negedge clk);
    run = 1; opCode = op; ZNC = z; mem_ack = 0;
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      run = 0; mem_ack = (i == ack_i);
      #4;
      r_pc[i] = pc_en; r_br[i] = BR; r_a[i] = a_we; r_b[i] = b_we; r_z[i] = znc_we;
      r_req[i] = mem_req; r_we[i] = WE; r_h[i] = halted; r_wb[i] = wb_sel; r_ret[i] = int'(retired);
    end
    mem_ack = 0;
  endtask

  initial begin
    int reqc, anya, wec;
    rst_n = 0; run = 0; opCode = 16'h0; ZNC = 3'b0; mem_ack = 0;
    repeat (2) @(negedge clk);
    #4;
    chk("reset_vec", 32'(dut_vec()), 32'h010);
    chk("reset_retired", 32'(retired), 0);

    @(negedge clk); rst_n = 1;

    // ALU, dst=B
    one_instr(16'h1800, 3'b000, 0, 5);
    chk("alu_c1_pc_en", 32'(r_pc[1]), 1);
    chk("alu_c3_b_we", 32'(r_b[3]), 1);
    chk("alu_c3_znc_we", 32'(r_z[3]), 1);
    chk("alu_c3_wb_sel", 32'(r_wb[3]), 0);
    anya = 0;
    for (int i = 1; i <= 5; i++) anya += int'(r_a[i]);
    chk("alu_a_never", 32'(anya), 0);
    chk("alu_ret_c4", 32'(r_ret[4]), 0);
    chk("alu_ret_c5", 32'(r_ret[5]), 1);

    // LOAD with ack on the 3rd MEM cycle
    one_instr(16'h8000, 3'b000, 5, 8);
    reqc = 0; wec = 0;
    for (int i = 1; i <= 8; i++) begin reqc += int'(r_req[i]); wec += int'(r_we[i]); end
    chk("load_req_cycles", 32'(reqc), 3);
    chk("load_we_low", 32'(wec), 0);
    chk("load_wb_a_we", 32'(r_a[6]), 1);
    chk("load_wb_sel", 32'(r_wb[6]), 1);
    chk("load_ret_c7", 32'(r_ret[7]), 1);
    chk("load_latency7", 32'(r_ret[8]), 2);

    // BRZ taken / not taken
    one_instr(16'hB000, 3'b100, 0, 5);
    chk("brz_taken_pc", 32'(r_pc[3]), 1);
    chk("brz_taken_br", 32'(r_br[3]), 1);
    one_instr(16'hB000, 3'b000, 0, 5);
    chk("brz_nt_pc", 32'(r_pc[3]), 0);
    chk("brz_nt_br", 32'(r_br[3]), 0);
    chk("brz_ret", 32'(r_ret[5]), 4);

    // HALT, then run 0->1 restarts
    one_instr(16'hF000, 3'b000, 0, 4);
    chk("halt_halted", 32'(r_h[4]), 1);
    chk("halt_ret_same", 32'(r_ret[4]), 4);
    @(negedge clk); run = 1; #4;
    chk("halt_still", 32'(halted), 1);
    @(negedge clk); run = 0; opCode = 16'h0000; #4;
    chk("halt_exit_fetch", 32'(pc_en), 1);
    chk("halt_exit_halted", 32'(halted), 0);
    repeat (3) @(negedge clk);
    #4;
    chk("halt_nop_ret", 32'(retired), 5);

    // Reset in the middle of a STORE
    @(negedge clk); run = 1; opCode = 16'h9000;
    @(negedge clk); run = 0;
    @(negedge clk);
    @(negedge clk); #4;
    chk("store_req", 32'(mem_req), 1);
    chk("store_we", 32'(WE), 1);
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1; #4;
    chk("midmem_vec", 32'(dut_vec()), 32'h010);
    chk("midmem_ret", 32'(retired), 0);
    @(negedge clk); mem_ack = 1; #4;
    chk("late_ack_vec", 32'(dut_vec()), 32'h010);
    @(negedge clk); mem_ack = 0;

    // Counter wrap via a stream of NOPs
    @(negedge clk); run = 1; opCode = 16'h0000;
    repeat (3 * RMASK + 1) @(negedge clk);
    #4;
    chk("wrap_max", 32'(retired), 32'(RMASK));
    repeat (3) @(negedge clk);
    #4;
    chk("wrap_zero", 32'(retired), 0);

    // Randomised traffic against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst_n   = ($urandom_range(0, 299) != 0);
      run     = ($urandom_range(0, 7) != 0);
      opCode  = 16'($urandom);
      ZNC     = 3'($urandom);
      mem_ack = ($urandom_range(0, 2) == 0);
    end
    @(negedge clk); rst_n = 1; run = 0; mem_ack = 0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
